// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV64M multiply/divide unit, one result bit per cycle
//
// Purpose:
//   Shift-add multiplier and restoring divider sharing one datapath. Executes
//   MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W forms behind a
//   valid/ready handshake. The FSM runs IDLE -> CALC -> FIX -> DONE -> IDLE.
//   Divide-by-zero and signed overflow skip straight from IDLE to DONE.
//
// Configuration:
//   MDU_ZERO_BYPASS_EN - when defined, a multiply with a zero operand, or a
//   divide/remainder with a zero dividend and non-zero divisor, also goes
//   IDLE -> DONE. Results are the same either way.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      synchronous reset, active low
//   i_flush      abort the in-flight op and return to IDLE (highest priority)
//   i_in_valid   request valid
//   o_in_ready   unit can accept (IDLE, not flushing, not in reset)
//   i_op         000 MUL 001 MULH 010 MULHSU 011 MULHU
//                100 DIV 101 DIVU 110 REM 111 REMU
//   i_word       W form: 32-bit op, result sign-extended (ignored at width 32)
//   i_src_a      rs1, multiplicand / dividend
//   i_src_b      rs2, multiplier / divisor
//   o_out_valid  result valid, held until i_out_ready
//   i_out_ready  consumer takes the result
//   o_result     result, all zeros while o_out_valid is low
//   o_busy       FSM is not in IDLE

module mdu_iter #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [2:0]            i_op,
  input  logic                  i_word,
  input  logic [DATA_WIDTH-1:0] i_src_a,
  input  logic [DATA_WIDTH-1:0] i_src_b,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W-1:0] MIN_FULL = {1'b1, {(W-1){1'b0}}};

  // Widen a 32-bit value to W bits, sign- or zero-extending from bit 31.
  function automatic logic [W-1:0] fn_wext(input logic [31:0] v, input logic sgn);
    logic [W-1:0] r;
    r = '0;
    r[31:0] = v;
    for (int k = 32; k < W; k++) begin
      r[k] = sgn & v[31];
    end
    return r;
  endfunction

  // State and datapath registers
  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_acc;     // product high half / partial remainder
  logic [W-1:0]  r_lo;      // multiplier then product low half / dividend then quotient
  logic [W-1:0]  r_mcand;   // multiplicand or divisor magnitude
  logic [W-1:0]  r_result;
  logic          r_is_div;
  logic          r_word;
  logic          r_high;    // MULH*: return the upper half of the product
  logic          r_rem_sel; // REM*: return the remainder
  logic          r_neg;     // negate product / quotient in FIX
  logic          r_rem_neg; // negate remainder in FIX

  // Operand preparation (combinational, used at accept)
  logic         w_word;
  logic         w_is_div;
  logic         w_a_sgn;
  logic         w_b_sgn;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [W-1:0] w_a_mag;
  logic [W-1:0] w_b_mag;
  logic         w_b_zero;
  logic         w_is_min;
  logic         w_div_zero;
  logic         w_div_ovf;
  logic         w_zero_byp;
  logic         w_direct;
  logic [W-1:0] w_direct_res;
  logic         w_accept;

  // Per-iteration datapath
  logic [W:0]   w_sum;
  logic [W:0]   w_shift;
  logic [W-1:0] w_diff;
  logic         w_ge;
  logic [W-1:0] w_acc_nxt;
  logic [W-1:0] w_lo_nxt;

  // Result fix-up
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_prod_s;
  logic [W-1:0]   w_mul_lo;
  logic [W-1:0]   w_mul_res;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;
  logic [W-1:0]   w_fix_raw;
  logic [W-1:0]   w_fix_res;

  assign w_word   = (W == 64) ? i_word : 1'b0;
  assign w_is_div = i_op[2];

  // MUL is handled as signed x signed: the low half of the product is the same
  // either way, and it lets every W-form multiply share the signed path.
  assign w_a_sgn = w_is_div ? ~i_op[0] : (w_word | (i_op[1:0] != 2'b11));
  assign w_b_sgn = w_is_div ? ~i_op[0] : (w_word | ~i_op[1]);

  assign w_a = w_word ? fn_wext(i_src_a[31:0], w_a_sgn) : i_src_a;
  assign w_b = w_word ? fn_wext(i_src_b[31:0], w_b_sgn) : i_src_b;

  assign w_a_neg = w_a_sgn & w_a[W-1];
  assign w_b_neg = w_b_sgn & w_b[W-1];
  assign w_a_mag = w_a_neg ? -w_a : w_a;
  assign w_b_mag = w_b_neg ? -w_b : w_b;

  assign w_b_zero   = (w_b == '0);
  assign w_is_min   = w_word ? (w_a[31:0] == 32'h8000_0000) : (w_a == MIN_FULL);
  assign w_div_zero = w_is_div & w_b_zero;
  assign w_div_ovf  = w_is_div & ~i_op[0] & w_is_min & (w_b == '1);

`ifdef MDU_ZERO_BYPASS_EN
  logic w_a_zero;
  assign w_a_zero   = (w_a == '0);
  assign w_zero_byp = w_is_div ? (w_a_zero & ~w_b_zero) : (w_a_zero | w_b_zero);
`else
  assign w_zero_byp = 1'b0;
`endif

  assign w_direct = w_div_zero | w_div_ovf | w_zero_byp;

  // Results that need no iteration. For overflow the prepared dividend already
  // is the (sign-extended) most negative value, i.e. the required quotient.
  always_comb begin
    w_direct_res = '0;
    if (w_div_zero) begin
      if (i_op[1]) begin
        w_direct_res = w_word ? fn_wext(w_a[31:0], 1'b1) : w_a;
      end else begin
        w_direct_res = '1;
      end
    end else if (w_div_ovf) begin
      w_direct_res = i_op[1] ? '0 : w_a;
    end
  end

  // Multiply: add multiplicand when the current multiplier bit is set, then
  // shift {acc, lo} right one place.
  assign w_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});

  // Divide: shift the next dividend bit into the partial remainder and subtract
  // the divisor if it fits. The difference is below the divisor so W bits hold it.
  assign w_shift = {r_acc, r_lo[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_mcand});
  assign w_diff  = w_shift[W-1:0] - r_mcand;

  always_comb begin
    w_acc_nxt = '0;
    w_lo_nxt  = '0;
    if (r_is_div) begin
      w_acc_nxt = w_ge ? w_diff : w_shift[W-1:0];
      w_lo_nxt  = {r_lo[W-2:0], w_ge};
    end else begin
      w_acc_nxt = w_sum[W:1];
      w_lo_nxt  = {w_sum[0], r_lo[W-1:1]};
    end
  end

  // A W-form multiply runs 32 iterations, so its product sits in {acc, lo}
  // shifted up by 32 with zeros below; the low word of the product is lo[63:32].
  assign w_prod    = {r_acc, r_lo};
  assign w_prod_s  = r_neg ? -w_prod : w_prod;
  assign w_mul_lo  = r_word ? (w_prod_s[W-1:0] >> 32) : w_prod_s[W-1:0];
  assign w_mul_res = r_high ? w_prod_s[2*W-1:W] : w_mul_lo;

  assign w_quo = r_neg ? -r_lo : r_lo;
  assign w_rem = r_rem_neg ? -r_acc : r_acc;

  assign w_fix_raw = r_is_div ? (r_rem_sel ? w_rem : w_quo) : w_mul_res;
  assign w_fix_res = r_word ? fn_wext(w_fix_raw[31:0], 1'b1) : w_fix_raw;

  assign o_in_ready  = i_rst_n & (r_state == S_IDLE) & ~i_flush;
  assign w_accept    = i_in_valid & o_in_ready;
  assign o_out_valid = (r_state == S_DONE);
  assign o_result    = o_out_valid ? r_result : '0;
  assign o_busy      = (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_result  <= '0;
      r_is_div  <= 1'b0;
      r_word    <= 1'b0;
      r_high    <= 1'b0;
      r_rem_sel <= 1'b0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div  <= w_is_div;
            r_word    <= w_word;
            r_high    <= ~w_is_div & ~w_word & (i_op[1:0] != 2'b00);
            r_rem_sel <= i_op[1];
            r_neg     <= w_a_neg ^ w_b_neg;
            r_rem_neg <= w_a_neg;
            r_acc     <= '0;
            r_count   <= w_word ? CW'(32) : CW'(W);
            if (w_is_div) begin
              r_mcand <= w_b_mag;
              // W-form dividend is parked in the upper word so the first of
              // the 32 iterations sees its bit 31.
              r_lo    <= w_word ? (w_a_mag << 32) : w_a_mag;
            end else begin
              r_mcand <= w_a_mag;
              r_lo    <= w_b_mag;
            end
            if (w_direct) begin
              r_result <= w_direct_res;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_acc   <= w_acc_nxt;
          r_lo    <= w_lo_nxt;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
        end
        default: begin
          if (i_out_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed table-driven bench for mdu_iter (DATA_WIDTH 64)

module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        word;
  logic [63:0] src_a;
  logic [63:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int n_checks = 0;
  int n_errs   = 0;

`ifdef MDU_ZERO_BYPASS_EN
  localparam int LZ64 = 1;
  localparam int LZ32 = 1;
`else
  localparam int LZ64 = 66;
  localparam int LZ32 = 34;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  mdu_iter #(.DATA_WIDTH(64)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op        (op),
    .i_word      (word),
    .i_src_a     (src_a),
    .i_src_b     (src_b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_result    (result),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
    end
  endtask

  // Present one request, wait for out_valid. lat = 1 when out_valid is up
  // right after the accept edge, N+2 for the iterative path.
  task automatic run_op(input string nm, input logic [2:0] o, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
    logic ok;
    @(negedge clk);
    op = o; word = w; src_a = a; src_b = b; in_valid = 1'b1;
    #1;
    chk({nm, " in_ready"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src_a = '0; src_b = '0;
    lat = 1;
    ok = 1'b0;
    while (lat < 200) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, " timeout"}, {63'd0, ok}, 64'd1);
    res = result;
  endtask

  task automatic release_op(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, " valid_after"}, {63'd0, out_valid}, 64'd0);
    chk({nm, " result_after"}, result, 64'd0);
    chk({nm, " ready_after"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] res;
    int          lat;
    int          seen;

    vecs[0]  = '{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
    vecs[1]  = '{3'b011, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66};
    vecs[2]  = '{3'b010, 1'b0, ONES, 64'd2, ONES, 66};
    vecs[3]  = '{3'b001, 1'b0, 64'hC000_0000_0000_0000, 64'd8, 64'hFFFF_FFFF_FFFF_FFFE, 66};
    vecs[4]  = '{3'b011, 1'b1, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 34};
    vecs[5]  = '{3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
    vecs[6]  = '{3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66};
    vecs[7]  = '{3'b100, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 66};
    vecs[8]  = '{3'b110, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 66};
    vecs[9]  = '{3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66};
    vecs[10] = '{3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 66};
    vecs[11] = '{3'b101, 1'b0, 64'd7, 64'd0, ONES, 1};
    vecs[12] = '{3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    vecs[13] = '{3'b100, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1};
    vecs[14] = '{3'b110, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 1};
    vecs[15] = '{3'b100, 1'b1, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1};
    vecs[16] = '{3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, ONES, 34};
    vecs[17] = '{3'b111, 1'b1, 64'h0000_0001_0000_0009, 64'h0000_0005_0000_0004, 64'd1, 34};
    vecs[18] = '{3'b101, 1'b1, 64'h0000_0000_0000_1234, 64'h0000_0001_0000_0000, ONES, 1};
    vecs[19] = '{3'b111, 1'b1, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1};
    vecs[20] = '{3'b000, 1'b0, 64'd12345, 64'd0, 64'd0, LZ64};
    vecs[21] = '{3'b100, 1'b0, 64'd0, 64'd5, 64'd0, LZ64};
    vecs[22] = '{3'b000, 1'b1, 64'h0000_DEAD_0000_0000, 64'h77, 64'd0, LZ32};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; word = 1'b0; src_a = '0; src_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst result", result, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst in_ready", {63'd0, in_ready}, 64'd1);

    // Table of directed vectors
    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("v%0d result", i), res, vecs[i].exp);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      release_op($sformatf("v%0d", i));
    end

    // DIVUW, then hold out_ready low for 5 cycles while a second request is
    // offered: the result must stay put and the request must be ignored.
    run_op("hold", 3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, res, lat);
    chk("hold result", res, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("hold latency", 64'(lat), 64'd34);
    @(negedge clk);
    op = 3'b000; word = 1'b0; src_a = 64'd3; src_b = 64'd3; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d valid", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("hold%0d result", k), result, 64'hFFFF_FFFF_FFFF_FFFE);
      chk($sformatf("hold%0d in_ready", k), {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    release_op("hold");

    // Flush at CALC cycle 10; a request offered in the flush cycle is not taken.
    @(negedge clk);
    op = 3'b000; word = 1'b0; src_a = 64'd7; src_b = 64'd9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("flush busy before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    op = 3'b101; src_a = 64'd1; src_b = 64'd0; in_valid = 1'b1;
    #1;
    chk("flush in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush busy", {63'd0, busy}, 64'd0);
    chk("flush out_valid", {63'd0, out_valid}, 64'd0);
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("flush no result", 64'(seen), 64'd0);

    // Flush together with out_ready in DONE: result dropped.
    run_op("fdone", 3'b110, 1'b0, 64'd5, 64'd0, res, lat);
    chk("fdone result", res, 64'd5);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    out_ready = 1'b0;
    chk("fdone out_valid", {63'd0, out_valid}, 64'd0);
    chk("fdone busy", {63'd0, busy}, 64'd0);

    // Unit still works after a flush.
    run_op("after", 3'b101, 1'b0, 64'd1000, 64'd33, res, lat);
    chk("after result", res, 64'd30);
    chk("after latency", 64'(lat), 64'd66);
    release_op("after");

    // Reset in the middle of an op.
    @(negedge clk);
    op = 3'b000; word = 1'b0; src_a = 64'd11; src_b = 64'd13; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst result", result, 64'd0);
    chk("midrst busy", {63'd0, busy}, 64'd0);
    chk("midrst in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("final", 3'b000, 1'b0, 64'd11, 64'd13, res, lat);
    chk("final result", res, 64'd143);
    release_op("final");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
